// File: rtl/mc_ctr_unit.sv
// mc_ctr_unit: multi-cycle MIPS control unit.
// Sequences each instruction over 3-5 cycles and drives the shared-ALU /
// unified-memory datapath. Adds a mem_ready handshake with a watchdog, an
// illegal-instruction trap and a per-instruction completion pulse.
// Optional feature macro: MC_CTR_JUMP_EN (opcode 000010 decodes to JUMP).
module mc_ctr_unit #(
   parameter int unsigned ALUCW   = 3,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic [1:0]       PCSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic [ALUCW-1:0] ALUControl,
   output logic             instr_done,
   output logic             illegal,
   output logic             timeout,
   output logic [3:0]       state
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
`ifdef MC_CTR_JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
   localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
   localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
   localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
   localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_RTYPE  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BEQ    = 4'd9,
      S_IMMEX  = 4'd10,
      S_IMMWB  = 4'd11,
      S_JUMP   = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   state_t           state_r;
   state_t           state_nx;
   logic [CW-1:0]    wd_cnt;
   logic             illegal_r;
   logic             timeout_r;
   logic             set_illegal;
   logic             set_timeout;
   logic             waiting;
   logic             wd_expire;
   logic             funct_ok;
   logic [ALUCW-1:0] alu_rtype;

   assign state   = state_r;
   assign illegal = illegal_r;
   assign timeout = timeout_r;

   // A memory request is outstanding and memory has not answered this cycle
   assign waiting   = mem_req && !mem_ready;
   assign wd_expire = (TIMEOUT > 0) && waiting && (wd_cnt == CW'(TIMEOUT - 1));

   // R-type funct decode: legality and ALU operation
   always_comb begin
      funct_ok  = 1'b1;
      alu_rtype = ALU_ADD;
      case (funct)
         FN_ADD:  alu_rtype = ALU_ADD;
         FN_SUB:  alu_rtype = ALU_SUB;
         FN_AND:  alu_rtype = ALU_AND;
         FN_OR:   alu_rtype = ALU_OR;
         FN_SLT:  alu_rtype = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_RESET;
      else        state_r <= state_nx;
   end

   // Next-state logic; watchdog expiry overrides any wait-state self-loop
   always_comb begin
      state_nx    = state_r;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state_r)
         S_RESET:  state_nx = S_FETCH;
         S_FETCH:  if (mem_ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     state_nx = S_MEMADR;
               OP_RTYPE: begin
                  if (funct_ok) begin
                     state_nx = S_RTYPE;
                  end else begin
                     state_nx    = S_TRAP;
                     set_illegal = 1'b1;
                  end
               end
               OP_BEQ:           state_nx = S_BEQ;
               OP_ADDI, OP_ANDI: state_nx = S_IMMEX;
`ifdef MC_CTR_JUMP_EN
               OP_J:             state_nx = S_JUMP;
`endif
               default: begin
                  state_nx    = S_TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
         S_MEMWB:  state_nx = S_FETCH;
         S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
         S_RTYPE:  state_nx = S_ALUWB;
         S_ALUWB:  state_nx = S_FETCH;
         S_BEQ:    state_nx = S_FETCH;
         S_IMMEX:  state_nx = S_IMMWB;
         S_IMMWB:  state_nx = S_FETCH;
         S_JUMP:   state_nx = S_FETCH;
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_RESET;
      endcase
      if (wd_expire) begin
         state_nx    = S_TRAP;
         set_timeout = 1'b1;
      end
   end

   // Datapath controls decoded from the registered state
   always_comb begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUControl = '0;
      instr_done = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_req    = 1'b1;
            IRWrite    = mem_ready;
            PCWrite    = mem_ready;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_RTYPE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b00;
            ALUControl = alu_rtype;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            Branch     = 1'b1;
            PCSrc      = 2'b01;
            instr_done = 1'b1;
         end
         S_IMMEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
         end
         S_IMMWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
`ifdef MC_CTR_JUMP_EN
         S_JUMP: begin
            PCSrc      = 2'b10;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Watchdog counter: restarts on every state change, counts unanswered requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    wd_cnt <= '0;
      else if (state_nx != state_r)  wd_cnt <= '0;
      else if (waiting)              wd_cnt <= wd_cnt + CW'(1);
   end

   // Sticky trap cause flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         if (set_illegal) illegal_r <= 1'b1;
         if (set_timeout) timeout_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mc_ctr_unit.sv
// Directed bench for mc_ctr_unit (default parameters, MC_CTR_JUMP_EN undefined).
module tb_mc_ctr_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
   logic [1:0] PCSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegDst, MemtoReg, RegWrite;
   logic [2:0] ALUControl;
   logic       instr_done, illegal, timeout;
   logic [3:0] state;
   logic [17:0] outs;

   int n_asrt = 0;
   int n_fail = 0;

   mc_ctr_unit #(.ALUCW(3), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal),
      .timeout(timeout), .state(state)
   );

   assign outs = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
                  ALUSrcA, ALUSrcB, RegDst, MemtoReg, RegWrite, ALUControl,
                  instr_done};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset and check the cleared state while it is held
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_state"}, 32'(state), 32'd0);
      chk({tag, "_rst_outs"}, 32'(outs), 32'd0);
      chk({tag, "_rst_flags"}, 32'({illegal, timeout}), 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk({tag, "_rel_state"}, 32'(state), 32'd0);
      cyc();
      chk({tag, "_fetch_state"}, 32'(state), 32'd1);
      chk({tag, "_fetch_req"}, 32'(mem_req), 32'd1);
   endtask

   logic [3:0] lw_seq [6];
   logic [5:0] fn_tab [5];
   logic [2:0] alu_tab [5];
   int         pulses;
   int         ncyc;

   initial begin
      lw_seq  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
      fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'd0;
      repeat (2) cyc();
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", 32'(outs), 32'd0);
      chk("reset_flags", 32'({illegal, timeout}), 32'd0);

      // lw with zero wait: 1,2,3,4,5,1
      rst_n = 1'b1;
      #1;
      chk("release_state", 32'(state), 32'd0);
      chk("release_outs", 32'(outs), 32'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("lw_state%0d", i), 32'(state), 32'(lw_seq[i]));
         chk($sformatf("lw_wb%0d", i), 32'({RegWrite, MemtoReg}),
             (lw_seq[i] == 4'd5) ? 32'd3 : 32'd0);
         if (i < 5) pulses += int'(instr_done);
         if (i == 0) begin
            chk("fetch_irw_pcw", 32'({IRWrite, PCWrite}), 32'd3);
            chk("fetch_alu", 32'({ALUSrcB, ALUControl}), 32'b01_010);
         end
         if (i == 2) chk("memadr_src", 32'({ALUSrcA, ALUSrcB}), 32'b1_10);
         if (i == 3) chk("memrd_iord", 32'({mem_req, IorD}), 32'd3);
      end
      chk("lw_pulses", 32'(pulses), 32'd1);

      // sw with 3 wait cycles in MEMWR: 7 cycles total
      opcode = 6'b101011;
      ncyc = 1;
      cyc(); ncyc++;
      chk("sw_decode", 32'(state), 32'd2);
      chk("decode_alusrcb", 32'(ALUSrcB), 32'd3);
      cyc(); ncyc++;
      chk("sw_memadr", 32'(state), 32'd3);
      mem_ready = 1'b0;
      cyc();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         #1;
         chk($sformatf("sw_memwr_state%0d", k), 32'(state), 32'd6);
         chk($sformatf("sw_memwrite%0d", k), 32'(MemWrite), 32'd1);
         chk($sformatf("sw_done%0d", k), 32'(instr_done), (k == 3) ? 32'd1 : 32'd0);
         ncyc++;
         cyc();
      end
      chk("sw_back_fetch", 32'(state), 32'd1);
      chk("sw_cycles", 32'(ncyc), 32'd7);

      // R-type add, sub, and, or, slt
      for (int i = 0; i < 5; i++) begin
         opcode = 6'b000000;
         funct  = fn_tab[i];
         cyc();
         cyc();
         chk($sformatf("rt_state%0d", i), 32'(state), 32'd7);
         chk($sformatf("rt_alu%0d", i), 32'(ALUControl), 32'(alu_tab[i]));
         chk($sformatf("rt_src%0d", i), 32'({ALUSrcA, ALUSrcB}), 32'b1_00);
         cyc();
         chk($sformatf("aluwb%0d", i), 32'({state, RegDst, RegWrite, instr_done}),
             32'({4'd8, 3'b111}));
         cyc();
         chk($sformatf("rt_fetch%0d", i), 32'(state), 32'd1);
      end

      // andi, addi, then beq
      opcode = 6'b001100;
      cyc(); cyc();
      chk("andi_immex", 32'({state, ALUControl, ALUSrcB}), 32'({4'd10, 3'b000, 2'b10}));
      cyc();
      chk("andi_immwb", 32'({state, RegWrite, instr_done}), 32'({4'd11, 2'b11}));
      cyc();
      opcode = 6'b001000;
      cyc(); cyc();
      chk("addi_immex", 32'({state, ALUControl}), 32'({4'd10, 3'b010}));
      cyc(); cyc();
      opcode = 6'b000100;
      cyc(); cyc();
      chk("beq_state", 32'(state), 32'd9);
      chk("beq_ctrl", 32'({Branch, PCSrc, ALUControl, instr_done}),
          32'({1'b1, 2'b01, 3'b110, 1'b1}));
      cyc();
      chk("beq_fetch", 32'(state), 32'd1);

      // j without the jump feature traps as illegal
      opcode = 6'b000010;
      cyc(); cyc();
      chk("j_trap", 32'({state, illegal, timeout}), 32'({4'd13, 2'b10}));
      chk("j_pcsrc", 32'(PCSrc), 32'd0);
      repeat (3) cyc();
      chk("j_trap_hold", 32'({state, outs}), 32'({4'd13, 18'd0}));
      do_reset("r1");

      // unknown opcode
      opcode = 6'b111111;
      cyc(); cyc();
      chk("op3f_trap", 32'({state, illegal}), 32'({4'd13, 1'b1}));
      do_reset("r2");

      // R-type with bad funct
      opcode = 6'b000000; funct = 6'b000000;
      cyc(); cyc();
      chk("fn00_trap", 32'({state, illegal}), 32'({4'd13, 1'b1}));
      do_reset("r3");

      // mem_ready on the 16th waiting cycle wins over the watchdog
      mem_ready = 1'b0; opcode = 6'b100011;
      for (int k = 0; k < 15; k++) cyc();
      chk("wd_edge_fetch", 32'(state), 32'd1);
      mem_ready = 1'b1;
      cyc();
      chk("wd_edge_win", 32'({state, timeout}), 32'({4'd2, 1'b0}));

      // 16 unanswered fetch cycles trigger the watchdog
      do_reset("r4");
      mem_ready = 1'b0;
      for (int k = 0; k < 15; k++) cyc();
      chk("wd_still_fetch", 32'({state, timeout}), 32'({4'd1, 1'b0}));
      cyc();
      chk("wd_trap", 32'({state, timeout, illegal}), 32'({4'd13, 2'b10}));

      // reset asserted in the middle of a MEMRD wait
      do_reset("r5");
      mem_ready = 1'b1; opcode = 6'b100011;
      cyc(); cyc(); cyc();
      chk("mid_memrd", 32'(state), 32'd4);
      mem_ready = 1'b0;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_outs", 32'(outs), 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_reset", 32'({state, mem_req}), 32'd0);
      cyc();
      chk("mid_rel_fetch", 32'({state, mem_req}), 32'({4'd1, 1'b1}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
